// File: rtl/dcache_2way_if.sv
// CPU-side request/response and memory-side line-transfer signals for dcache_2way.
interface dcache_2way_if #(
    parameter int unsigned OFF_W = 4,
    parameter int unsigned MEM_W = 128
);
    logic              read;
    logic              write;
    logic [2:0]        funct3;
    logic [31:0]       address;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic              busywait;
    logic              misaligned;
    logic              mem_read;
    logic              mem_write;
    logic [31-OFF_W:0] mem_address;
    logic [MEM_W-1:0]  mem_writedata;
    logic [MEM_W-1:0]  mem_readdata;
    logic              mem_busywait;

    // Cache view: serves the CPU, masters the memory.
    modport slave (
        input  read, write, funct3, address, writedata, mem_readdata, mem_busywait,
        output readdata, busywait, misaligned, mem_read, mem_write, mem_address, mem_writedata
    );

    // Environment view: CPU plus line memory.
    modport master (
        output read, write, funct3, address, writedata, mem_readdata, mem_busywait,
        input  readdata, busywait, misaligned, mem_read, mem_write, mem_address, mem_writedata
    );
endinterface

// File: rtl/dcache_2way.sv
// 2-way set-associative write-back/write-allocate data cache with per-set LRU.
// Optional hit/miss counters are built when DCACHE_PERF_CNT_EN is defined.
module dcache_2way #(
    parameter int unsigned SETS        = 8,
    parameter int unsigned BLOCK_WORDS = 4
) (
    input  logic         clock,
    input  logic         reset,
    dcache_2way_if.slave bus
`ifdef DCACHE_PERF_CNT_EN
    ,
    output logic [31:0]  hit_count,
    output logic [31:0]  miss_count
`endif
);
    localparam int unsigned OFF_W = $clog2(BLOCK_WORDS * 4);
    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned TAG_W = 32 - IDX_W - OFF_W;
    localparam int unsigned MEM_W = BLOCK_WORDS * 32;
    localparam int unsigned BIT_W = OFF_W + 3;

    typedef enum logic [1:0] {IDLE, WRITEBACK, FILL, UPDATE} state_t;

    state_t            state_q, state_d;
    logic [SETS-1:0]   valid_q [2];
    logic [SETS-1:0]   dirty_q [2];
    logic [SETS-1:0]   lru_q;
    logic [TAG_W-1:0]  tag_q  [2][SETS];
    logic [MEM_W-1:0]  data_q [2][SETS];
    logic              victim_q;
    logic [MEM_W-1:0]  fill_q;

    logic [TAG_W-1:0]  tag;
    logic [IDX_W-1:0]  idx;
    logic [OFF_W-1:0]  woff;
    logic [BIT_W-1:0]  wbit;
    logic              req, mis, access, hit0, hit1, hit, hit_way;
    logic              victim, victim_dirty, hit_done, miss_start;
    logic [MEM_W-1:0]  hit_line, upd_line;
    logic [31:0]       word, shifted, load_data, wdata_al;
    logic [3:0]        wmask;

    // Address split and access qualification
    assign tag    = bus.address[31 -: TAG_W];
    assign idx    = bus.address[OFF_W +: IDX_W];
    assign woff   = bus.address[OFF_W-1:0] & ~OFF_W'(3);
    assign wbit   = {woff, 3'b000};
    assign req    = bus.read | bus.write;
    assign mis    = req & (((bus.funct3[1:0] == 2'b01) & bus.address[0]) |
                           (bus.funct3[1] & (bus.address[1:0] != 2'b00)));
    assign access = req & ~mis;

    assign hit0     = valid_q[0][idx] & (tag_q[0][idx] == tag);
    assign hit1     = valid_q[1][idx] & (tag_q[1][idx] == tag);
    assign hit      = hit0 | hit1;
    assign hit_way  = hit1;
    assign hit_line = hit1 ? data_q[1][idx] : data_q[0][idx];

    // Invalid way first (way 0 preferred), otherwise the LRU way
    assign victim       = ~valid_q[0][idx] ? 1'b0 : (~valid_q[1][idx] ? 1'b1 : lru_q[idx]);
    assign victim_dirty = valid_q[victim][idx] & dirty_q[victim][idx];

    // Load extraction with sign/zero extension
    assign word    = hit_line[wbit +: 32];
    assign shifted = word >> {bus.address[1:0], 3'b000};
    always_comb begin
        load_data = word;
        case (bus.funct3)
            3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_data = {24'd0, shifted[7:0]};
            3'b101:  load_data = {16'd0, shifted[15:0]};
            default: load_data = word;
        endcase
    end

    // Store lane mask and lane-aligned data, merged into the hit line
    always_comb begin
        wmask    = 4'b1111;
        wdata_al = bus.writedata;
        case (bus.funct3[1:0])
            2'b00: begin
                wmask    = 4'b0001 << bus.address[1:0];
                wdata_al = bus.writedata << {bus.address[1:0], 3'b000};
            end
            2'b01: begin
                wmask    = 4'b0011 << {bus.address[1], 1'b0};
                wdata_al = bus.writedata << {bus.address[1], 4'b0000};
            end
            default: begin
                wmask    = 4'b1111;
                wdata_al = bus.writedata;
            end
        endcase
        upd_line = hit_line;
        for (int b = 0; b < 4; b++) begin
            if (wmask[b]) upd_line[wbit + BIT_W'(8 * b) +: 8] = wdata_al[8 * b +: 8];
        end
    end

    // Next state and bus outputs; everything is quiet while reset is held
    always_comb begin
        state_d           = state_q;
        bus.readdata      = '0;
        bus.busywait      = 1'b0;
        bus.misaligned    = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.mem_address   = '0;
        bus.mem_writedata = '0;
        hit_done          = 1'b0;
        miss_start        = 1'b0;
        if (!reset) begin
            bus.misaligned = mis;
            case (state_q)
                IDLE: begin
                    if (access) begin
                        if (hit) begin
                            hit_done = 1'b1;
                            if (!bus.write) bus.readdata = load_data;
                        end else begin
                            bus.busywait = 1'b1;
                            miss_start   = 1'b1;
                            state_d      = victim_dirty ? WRITEBACK : FILL;
                        end
                    end
                end
                WRITEBACK: begin
                    bus.busywait      = 1'b1;
                    bus.mem_write     = 1'b1;
                    bus.mem_address   = {tag_q[victim_q][idx], idx};
                    bus.mem_writedata = data_q[victim_q][idx];
                    if (!bus.mem_busywait) state_d = FILL;
                end
                FILL: begin
                    bus.busywait    = 1'b1;
                    bus.mem_read    = 1'b1;
                    bus.mem_address = bus.address[31:OFF_W];
                    if (!bus.mem_busywait) state_d = UPDATE;
                end
                UPDATE: begin
                    bus.busywait = 1'b1;
                    state_d      = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State, line status bits and transfer capture
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            valid_q[0] <= '0;
            valid_q[1] <= '0;
            dirty_q[0] <= '0;
            dirty_q[1] <= '0;
            lru_q      <= '0;
            victim_q   <= 1'b0;
            fill_q     <= '0;
        end else begin
            state_q <= state_d;
            if (miss_start) victim_q <= victim;
            if (state_q == FILL && !bus.mem_busywait) fill_q <= bus.mem_readdata;
            if (hit_done) begin
                lru_q[idx] <= ~hit_way;
                if (bus.write) dirty_q[hit_way][idx] <= 1'b1;
            end
            if (state_q == UPDATE) begin
                valid_q[victim_q][idx] <= 1'b1;
                dirty_q[victim_q][idx] <= 1'b0;
                lru_q[idx]             <= ~victim_q;
            end
        end
    end

    // Tag and data arrays carry no reset; validity gates their use
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (state_q == UPDATE) begin
                data_q[victim_q][idx] <= fill_q;
                tag_q[victim_q][idx]  <= tag;
            end else if (hit_done && bus.write) begin
                data_q[hit_way][idx] <= upd_line;
            end
        end
    end

`ifdef DCACHE_PERF_CNT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit_done)   hit_count  <= hit_count + 32'd1;
            if (miss_start) miss_count <= miss_count + 32'd1;
        end
    end
`endif
endmodule
